// File: rtl/synaptic_weight_updater.sv
// synaptic_weight_updater: buffers signed weight deltas in a small FIFO and
// applies them to a local weight memory through a serialized read-modify-write
// FSM with clamping to [W_MIN, W_MAX]. A registered read port serves weights.
module synaptic_weight_updater #(
    parameter int WEIGHT_W   = 16,
    parameter int NSYN       = 16,
    parameter int ADDR_W     = $clog2(NSYN),
    parameter int FIFO_DEPTH = 4,
    parameter logic signed [WEIGHT_W-1:0] W_MIN  = '0,
    parameter logic signed [WEIGHT_W-1:0] W_MAX  = WEIGHT_W'(1023),
    parameter logic signed [WEIGHT_W-1:0] W_INIT = WEIGHT_W'(256)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                dw_valid_i,
    output logic                dw_ready_o,
    input  logic [WEIGHT_W-1:0] dw_i,
    input  logic [ADDR_W-1:0]   dw_addr_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [WEIGHT_W-1:0] rd_data_o,
    output logic                upd_done_o,
    output logic [ADDR_W-1:0]   upd_addr_o,
    output logic                sat_o,
    output logic                busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {INIT, IDLE, RD, CALC, WR} state_t;

    state_t                      state_q;
    logic [ADDR_W-1:0]           initAddr_q;

    logic [ADDR_W-1:0]           fifoAddr_q [FIFO_DEPTH];
    logic [WEIGHT_W-1:0]         fifoDw_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]            wrPtr_q;
    logic [PTR_W-1:0]            rdPtr_q;
    logic [CNT_W-1:0]            count_q;

    logic [ADDR_W-1:0]           curAddr_q;
    logic [WEIGHT_W-1:0]         curDw_q;
    logic [WEIGHT_W-1:0]         weight_q;
    logic [WEIGHT_W-1:0]         result_q;
    logic                        resultSat_q;

    logic [WEIGHT_W-1:0]         mem [NSYN];
    logic [WEIGHT_W-1:0]         rdData_q;
    logic                        updDone_q;
    logic [ADDR_W-1:0]           updAddr_q;
    logic                        sat_q;

    logic                        fifoFull;
    logic                        fifoEmpty;
    logic                        dwReady;
    logic                        push;
    logic                        pop;

    logic signed [WEIGHT_W:0]    sum;
    logic signed [WEIGHT_W:0]    maxExt;
    logic signed [WEIGHT_W:0]    minExt;
    logic [WEIGHT_W-1:0]         result_d;
    logic                        sat_d;

    logic                        memWe;
    logic [ADDR_W-1:0]           memAddr;
    logic [WEIGHT_W-1:0]         memData;

    assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);
    // A full FIFO refuses input even if a pop frees a slot on the same edge.
    assign dwReady   = !fifoFull && (state_q != INIT);
    // Zero deltas are accepted for flow control but never change a weight.
    assign push      = clk_en && dw_valid_i && dwReady && (dw_i != '0);
    assign pop       = clk_en && (state_q == IDLE) && !fifoEmpty;

    assign dw_ready_o = dwReady;
    assign busy_o     = (state_q != IDLE) || !fifoEmpty;
    assign rd_data_o  = rdData_q;
    assign upd_done_o = updDone_q;
    assign upd_addr_o = updAddr_q;
    assign sat_o      = sat_q;

    // Delta request FIFO: circular buffer with an occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifoAddr_q[wrPtr_q] <= dw_addr_i;
                fifoDw_q[wrPtr_q]   <= dw_i;
                wrPtr_q             <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Widen by one bit so the add cannot wrap, then clamp into the weight range.
    always_comb begin
        sum      = {weight_q[WEIGHT_W-1], weight_q} + {curDw_q[WEIGHT_W-1], curDw_q};
        maxExt   = {W_MAX[WEIGHT_W-1], W_MAX};
        minExt   = {W_MIN[WEIGHT_W-1], W_MIN};
        result_d = sum[WEIGHT_W-1:0];
        sat_d    = 1'b0;
        if (sum > maxExt) begin
            result_d = W_MAX;
            sat_d    = 1'b1;
        end else if (sum < minExt) begin
            result_d = W_MIN;
            sat_d    = 1'b1;
        end
    end

    // Init sweep and serialized read-modify-write sequencing with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            initAddr_q  <= '0;
            curAddr_q   <= '0;
            curDw_q     <= '0;
            weight_q    <= '0;
            result_q    <= '0;
            resultSat_q <= 1'b0;
            updDone_q   <= 1'b0;
            updAddr_q   <= '0;
            sat_q       <= 1'b0;
        end else if (clk_en) begin
            updDone_q <= 1'b0;
            case (state_q)
                INIT: begin
                    initAddr_q <= initAddr_q + 1'b1;
                    if (initAddr_q == ADDR_W'(NSYN - 1)) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!fifoEmpty) begin
                        curAddr_q <= fifoAddr_q[rdPtr_q];
                        curDw_q   <= fifoDw_q[rdPtr_q];
                        state_q   <= RD;
                    end
                end
                RD: begin
                    weight_q <= mem[curAddr_q];
                    state_q  <= CALC;
                end
                CALC: begin
                    result_q    <= result_d;
                    resultSat_q <= sat_d;
                    state_q     <= WR;
                end
                WR: begin
                    updDone_q <= 1'b1;
                    updAddr_q <= curAddr_q;
                    sat_q     <= resultSat_q;
                    state_q   <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // The memory has one write port shared by the init sweep and the WR step.
    assign memWe   = clk_en && !rst && ((state_q == INIT) || (state_q == WR));
    assign memAddr = (state_q == INIT) ? initAddr_q : curAddr_q;
    assign memData = (state_q == INIT) ? W_INIT : result_q;

    // Weight memory write port.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    // Registered read port; a same-edge write to the same address returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= '0;
        end else if (clk_en) begin
            rdData_q <= mem[rd_addr_i];
        end
    end

endmodule

// File: doc/synaptic_weight_updater.md
# synaptic_weight_updater

Applies signed weight deltas from the plasticity stage to a local synaptic weight register file. Each delta arrives with a synapse index and is buffered in a small FIFO. A 4-state read-modify-write FSM adds the delta to the stored weight and clamps the result to [W_MIN, W_MAX]. The block sits directly downstream of the STDP/dopamine plasticity stage, takes its `dw` output, and serves current weights to the synapse/neuron datapath through a registered read port.

## Interface
- WEIGHT_W, 16, width of weights and deltas (signed)
- NSYN, 16, number of synapses stored
- ADDR_W, $clog2(NSYN), synapse index width
- FIFO_DEPTH, 4, delta request FIFO entries (power of two)
- W_MIN, 0, lower clamp (signed)
- W_MAX, 1023, upper clamp (signed)
- W_INIT, 256, weight value written at init

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  global tick enable; when 0, all state (FSM, FIFO, memory, outputs) holds
- dw_valid_i  in  1  delta request valid
- dw_ready_o  out  1  FIFO can accept
- dw_i  in  WEIGHT_W  signed weight delta
- dw_addr_i  in  ADDR_W  target synapse index
- rd_addr_i  in  ADDR_W  weight read address
- rd_data_o  out  WEIGHT_W  registered weight read data
- upd_done_o  out  1  one-cycle pulse: a write completed
- upd_addr_o  out  ADDR_W  address of the completed write
- sat_o  out  1  qualified by upd_done_o: the result was clamped
- busy_o  out  1  FSM not IDLE or FIFO non-empty

## Operation
- States: INIT, IDLE, RD, CALC, WR.
- INIT: entered on rst.
  - Sweeps addresses 0..NSYN-1 and writes W_INIT, one per enabled cycle, then goes to IDLE.
  - dw_ready_o=0 throughout.
- Accept rule: a request is accepted on an enabled edge with dw_valid_i && dw_ready_o.
  - dw_ready_o = !fifo_full && state!=INIT.
  - A request with dw_i==0 is accepted but not enqueued; it produces no upd_done_o.
- IDLE with FIFO non-empty: pop the head, latch {addr, dw}, go to RD. Otherwise stay in IDLE.
- RD: w_q <= mem[addr]; go to CALC.
- CALC: sum = sign-extend(w_q) + sign-extend(dw) at WEIGHT_W+1 bits, no wrap.
  - sum > W_MAX gives W_MAX with sat=1.
  - sum < W_MIN gives W_MIN with sat=1.
  - Otherwise the result is sum[WEIGHT_W-1:0] with sat=0.
  - Go to WR.
- WR: mem[addr] <= result; upd_done_o<=1, upd_addr_o<=addr, sat_o<=sat; go to IDLE.
- Updates are strictly serialized, so back-to-back deltas to the same address accumulate correctly with no hazard.
- Read port: rd_data_o <= mem[rd_addr_i] on every enabled edge, independent of the FSM.
  - If a write and a read to the same address share an edge, rd_data_o returns the old value.
- FIFO full: dw_ready_o=0 even if a pop happens in the same cycle (no push-through).
- Reset mid-operation: FIFO is flushed, in-flight update is discarded, all weights are re-initialised via INIT.

## Timing
- Reset values: dw_ready_o=0, rd_data_o=0, upd_done_o=0, upd_addr_o=0, sat_o=0, busy_o=1 (INIT).
- INIT takes NSYN enabled cycles; dw_ready_o rises on the edge that leaves INIT.
- Update latency, starting from an empty FIFO in IDLE:
  - Accept at edge E0, pop at E1, RD at E2, CALC at E3.
  - WR at E4: memory updated, upd_done_o=1 for the cycle following E4.
  - A read issued with rd_addr_i at edge E5 returns the new weight after E5.
- Throughput: one update per 4 enabled cycles. Sustained input at a higher rate fills the FIFO and deasserts dw_ready_o.
- clk_en=0 cycles stretch every interval above. upd_done_o holds its value while clk_en=0 and is cleared at the next enabled edge.

## Test plan
- Reset and init: rst for 2 cycles, then run 16 enabled cycles. busy_o=1 and dw_ready_o=0 during INIT; afterwards reading addresses 0..15 returns 256 each.
- Single update: dw_i=+4 to addr 3. upd_done_o appears 4 enabled cycles after accept with upd_addr_o=3 and sat_o=0. Address 3 then reads 260.
- Saturation, both directions:
  - dw=+1000 to addr 5 gives 1023 with sat_o=1.
  - Then dw=-3 gives 1020 with sat_o=0.
  - dw=-300 to addr 6 gives 0 with sat_o=1.
- Backpressure: 6 consecutive valid requests (dw=+1, addr 0). dw_ready_o drops once the FIFO is full. All accepted requests complete with no loss; addr 0 ends at 256 + accepted count.
- Zero delta and clk_en gating:
  - dw=0 is accepted and produces no upd_done_o.
  - A +4 update with clk_en toggled 1/0 every cycle completes after 4 enabled edges (8 clocks).
- Reset mid-operation: assert rst while in CALC. No upd_done_o follows; the FIFO is empty; after INIT all weights read 256.
